uart_tx_feeder: RTL

Upstream feeder for the MiniUART transmit path. Buffers bytes from a local producer (CPU-side bridge or test logic) in a DEPTH-entry FIFO. Acts as a single WISHBONE master on the MiniUART slave port: polls LSR and writes each byte to the DATA register only when the transmitter reports idle. Optionally programs DIVT once after reset, so the producer never touches UART registers directly.

---
 rtl/uart_pkg.sv | 11 +
 rtl/uart_tx_feeder_if.sv | 11 +
 rtl/sync_byte_fifo.sv | 35 +++
 rtl/uart_tx_feeder.sv | 90 +++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: MiniUART register map, LSR bit positions and feeder FSM encoding
package uart_pkg;
  localparam logic [2:0] OFF_UART_DATA = 3'd0;
  localparam logic [2:0] OFF_UART_LSR = 3'd4;
  localparam logic [2:0] OFF_UART_DIVR = 3'd6;
  localparam logic [2:0] OFF_UART_DIVT = 3'd7;
  localparam int LSR_TS_BIT = 5;
  localparam int LSR_RS_BIT = 0;
  localparam logic [15:0] BAUD_SND_9600 = 16'd5208;
  typedef enum logic [2:0] {ST_INIT, ST_IDLE, ST_POLL, ST_WRITE, ST_GAP} feeder_state_t;
endpackage

// File: rtl/uart_tx_feeder_if.sv
// uart_tx_feeder_if: WISHBONE link between the feeder (master) and the MiniUART slave port
interface uart_tx_feeder_if;
  logic [2:0] ADD_O;
  logic [31:0] DAT_O;
  logic [31:0] DAT_I;
  logic STB_O;
  logic WE_O;
  logic ACK_I;
  modport master(output ADD_O, DAT_O, STB_O, WE_O, input DAT_I, ACK_I);
  modport slave(input ADD_O, DAT_O, STB_O, WE_O, output DAT_I, ACK_I);
endinterface

// File: rtl/sync_byte_fifo.sv
// sync_byte_fifo: power-of-two byte FIFO; a push while full is accepted when a pop lands in the same cycle
module sync_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                    CLK_I,
  input  logic                    RST_I,
  input  logic                    push,
  input  logic                    pop,
  input  logic [7:0]              din,
  output logic [7:0]              head,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic do_push;
  assign do_push = push && (!full || pop);
  assign head = mem[rptr];
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  always_ff @(posedge CLK_I)
    if (do_push) mem[wptr] <= din;
  always_ff @(posedge CLK_I or posedge RST_I)
    if (RST_I) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(pop);
    end
endmodule

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: buffers producer bytes and writes them to MiniUART DATA whenever LSR reports the transmitter idle
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int          DEPTH      = 16,
  parameter int          GAP_CYCLES = 4,
  parameter bit          INIT_DIVT  = 1'b1,
  parameter logic [15:0] DIVT_VAL   = BAUD_SND_9600
) (
  input  logic                    CLK_I,
  input  logic                    RST_I,
  input  logic                    wr_en,
  input  logic [7:0]              wr_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  input  logic                    clr_ovf,
  output logic                    busy,
  uart_tx_feeder_if.master        wb
);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  feeder_state_t state, state_n;
  logic [GW-1:0] gap_cnt, gap_cnt_n;
  logic stb_n, we_n, pop, ack;
  logic [2:0] add_n;
  logic [31:0] dat_n;
  logic [7:0] head;
  assign ack = wb.STB_O && wb.ACK_I;
  assign busy = state != ST_IDLE || !empty;
  sync_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK_I(CLK_I), .RST_I(RST_I), .push(wr_en), .pop(pop), .din(wr_data),
    .head(head), .full(full), .empty(empty), .count(count)
  );
  // bus outputs are computed for the state being entered, then registered
  always_comb begin
    state_n = state;
    gap_cnt_n = gap_cnt;
    stb_n = 1'b0;
    we_n = 1'b0;
    add_n = wb.ADD_O;
    dat_n = wb.DAT_O;
    pop = 1'b0;
    case (state)
      ST_INIT: if (ack) begin
        state_n = ST_GAP;
        gap_cnt_n = '0;
      end else {stb_n, we_n, add_n, dat_n} = {2'b11, OFF_UART_DIVT, 16'b0, DIVT_VAL};
      ST_IDLE: if (!empty) begin
        state_n = ST_POLL;
        {stb_n, add_n} = {1'b1, OFF_UART_LSR};
      end
      ST_POLL: if (ack) begin
        if (wb.DAT_I[LSR_TS_BIT]) begin
          state_n = ST_WRITE;
          {stb_n, we_n, add_n, dat_n} = {2'b11, OFF_UART_DATA, 24'b0, head};
        end
      end else {stb_n, add_n} = {1'b1, OFF_UART_LSR};
      ST_WRITE: if (ack) begin
        pop = 1'b1;
        state_n = ST_GAP;
        gap_cnt_n = '0;
      end else {stb_n, we_n} = 2'b11;
      ST_GAP: if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
        // fall straight into the next poll so the byte period is POLL + WRITE + GAP_CYCLES
        state_n = empty ? ST_IDLE : ST_POLL;
        {stb_n, add_n} = empty ? {1'b0, add_n} : {1'b1, OFF_UART_LSR};
      end else gap_cnt_n = gap_cnt + 1'b1;
      default: state_n = ST_IDLE;
    endcase
  end
  always_ff @(posedge CLK_I or posedge RST_I)
    if (RST_I) begin
      state <= INIT_DIVT ? ST_INIT : ST_IDLE;
      gap_cnt <= '0;
      wb.STB_O <= 1'b0;
      wb.WE_O <= 1'b0;
      wb.ADD_O <= '0;
      wb.DAT_O <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_n;
      gap_cnt <= gap_cnt_n;
      wb.STB_O <= stb_n;
      wb.WE_O <= we_n;
      wb.ADD_O <= add_n;
      wb.DAT_O <= dat_n;
      overflow <= (wr_en && full && !pop) || (overflow && !clr_ovf);
    end
endmodule
